reg2tl_adapter: RTL and testbench
=================================

REG2TL_ADAPTER -- requirements
Module: reg2tl_adapter

Interface
REQ-001 Parameter SOURCE_ID, default 0, TL source ID driven on every A-channel request.
REQ-002 Port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Ports host_i_req  input  1 / host_o_gnt  output  1  request and same-cycle grant.
REQ-005 Ports host_i_we  input  1 / host_i_addr  input  TL_A_WIDTH_ADDRESS / host_i_wmask  input  TL_A_WIDTH_MASK / host_i_wdata  input  TL_A_WIDTH_DATA  request fields, valid while host_i_req=1.
REQ-006 Ports host_o_rvalid  output  1 / host_o_rdata  output  TL_D_WIDTH_DATA / host_o_err  output  1  single-cycle completion pulse with read data and error flag.
REQ-007 Ports tl_o_a_opcode, tl_o_a_param, tl_o_a_size, tl_o_a_source, tl_o_a_address, tl_o_a_mask, tl_o_a_data, tl_o_a_corrupt  outputs  TL_A_WIDTH_*  A-channel fields; tl_o_a_valid  output  1; tl_i_a_ready  input  1.
REQ-008 Ports tl_i_d_opcode, tl_i_d_param, tl_i_d_size, tl_i_d_source, tl_i_d_sink, tl_i_d_denied, tl_i_d_data, tl_i_d_corrupt  inputs  TL_D_WIDTH_*  D-channel fields; tl_i_d_valid  input  1; tl_o_d_ready  output  1.

Function
REQ-009 FSM states IDLE, A_SEND, D_WAIT, RESP; exactly one outstanding transaction.
REQ-010 host_o_gnt = host_i_req in IDLE, else 0 (combinational); grant latches we/addr/wmask/wdata into internal registers.
REQ-011 IDLE + grant + host_i_addr[1:0]=0 -> A_SEND; IDLE + grant + misaligned addr -> RESP with err=1, rdata=0, no TL traffic.
REQ-012 A_SEND: tl_o_a_valid=1, all A fields driven from registers, held stable until tl_i_a_ready=1; then -> D_WAIT.
REQ-013 A opcode: we=0 -> Get (4); we=1 and wmask=4'hF -> PutFullData (0); we=1 otherwise -> PutPartialData (1).
REQ-014 A fields: param=0, size=2, source=SOURCE_ID, address=latched addr, corrupt=0; Get -> mask=4'hF, data=0; Put -> mask=latched wmask, data=latched wdata.
REQ-015 tl_o_a_valid=0 in every state except A_SEND.
REQ-016 D_WAIT: tl_o_d_ready=1; tl_o_d_ready=0 in all other states; D beat accepted when tl_i_d_valid=1 in D_WAIT -> RESP.
REQ-017 Accepted-beat error = d_denied | d_corrupt | (d_source != SOURCE_ID) | (Get and d_opcode != AccessAckData(1)) | (Put and d_opcode != AccessAck(0)).
REQ-018 Read data registered from tl_i_d_data only for error-free Get; otherwise rdata=0.
REQ-019 RESP: host_o_rvalid=1 for exactly one cycle, with rdata/err valid that cycle; -> IDLE next cycle.
REQ-020 host_o_rdata and host_o_err hold last values outside RESP; rvalid=0 outside RESP.
REQ-021 Minimum latency with a_ready=1 and d_valid=1 immediately: grant cycle N, a_valid cycle N+1, d accept cycle N+2, rvalid cycle N+3.
REQ-022 host_i_req asserted in A_SEND/D_WAIT/RESP is ignored (gnt=0) until IDLE; back-to-back request granted in the IDLE cycle right after RESP.
REQ-023 D beats arriving outside D_WAIT are not accepted (d_ready=0) and do not change state.

Reset
REQ-024 rst=1 at a rising edge -> state IDLE; host_o_rvalid=0, host_o_rdata=0, host_o_err=0, all latched request registers=0.
REQ-025 During and after reset, tl_o_a_valid=0, tl_o_d_ready=0, host_o_gnt=0 while rst=1.
REQ-026 Reset mid-transaction (A_SEND or D_WAIT) abandons it; no rvalid pulse is produced for it.

Verification
REQ-027 Read: req, we=0, addr=0x100; a_ready=1, d: opcode=1, source=SOURCE_ID, data=0xDEADBEEF -> a_opcode=4, mask=0xF; rvalid at N+3, rdata=0xDEADBEEF, err=0.
REQ-028 Write full/partial: we=1, wmask=0xF, data=0x12345678 -> a_opcode=0; wmask=0x3 -> a_opcode=1, mask=0x3; d opcode=0 -> rvalid, err=0, rdata=0.
REQ-029 Backpressure: a_ready=0 for 5 cycles then 1, d_valid delayed 3 cycles -> A fields stable all 5 cycles, single rvalid pulse, gnt=0 throughout.
REQ-030 Errors: d_denied=1 -> err=1, rdata=0; Get answered with opcode=0 -> err=1; d_source=SOURCE_ID+1 -> err=1.
REQ-031 Misaligned addr=0x102 -> gnt=1, no a_valid, rvalid next cycle with err=1, rdata=0.
REQ-032 Reset in D_WAIT -> next cycle IDLE, d_ready=0, no rvalid; a following read completes normally.

Source files
------------

// File: rtl/reg2tl_adapter.sv
`default_nettype none
// ============================================================================
// Module   : reg2tl_adapter
// Purpose  : Bridges a simple req/gnt register host onto a TL-UL A/D channel
//            pair, one outstanding transaction at a time.
// Revision : 1.0
// ============================================================================
module reg2tl_adapter #(
    parameter int unsigned SOURCE_ID          = 0,
    parameter int unsigned TL_A_WIDTH_OPCODE  = 3,
    parameter int unsigned TL_A_WIDTH_PARAM   = 3,
    parameter int unsigned TL_A_WIDTH_SIZE    = 2,
    parameter int unsigned TL_A_WIDTH_SOURCE  = 8,
    parameter int unsigned TL_A_WIDTH_ADDRESS = 32,
    parameter int unsigned TL_A_WIDTH_MASK    = 4,
    parameter int unsigned TL_A_WIDTH_DATA    = 32,
    parameter int unsigned TL_D_WIDTH_OPCODE  = 3,
    parameter int unsigned TL_D_WIDTH_PARAM   = 3,
    parameter int unsigned TL_D_WIDTH_SIZE    = 2,
    parameter int unsigned TL_D_WIDTH_SOURCE  = 8,
    parameter int unsigned TL_D_WIDTH_SINK    = 1,
    parameter int unsigned TL_D_WIDTH_DATA    = 32
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          host_i_req,
    output logic                          host_o_gnt,
    input  logic                          host_i_we,
    input  logic [TL_A_WIDTH_ADDRESS-1:0] host_i_addr,
    input  logic [TL_A_WIDTH_MASK-1:0]    host_i_wmask,
    input  logic [TL_A_WIDTH_DATA-1:0]    host_i_wdata,
    output logic                          host_o_rvalid,
    output logic [TL_D_WIDTH_DATA-1:0]    host_o_rdata,
    output logic                          host_o_err,

    output logic [TL_A_WIDTH_OPCODE-1:0]  tl_o_a_opcode,
    output logic [TL_A_WIDTH_PARAM-1:0]   tl_o_a_param,
    output logic [TL_A_WIDTH_SIZE-1:0]    tl_o_a_size,
    output logic [TL_A_WIDTH_SOURCE-1:0]  tl_o_a_source,
    output logic [TL_A_WIDTH_ADDRESS-1:0] tl_o_a_address,
    output logic [TL_A_WIDTH_MASK-1:0]    tl_o_a_mask,
    output logic [TL_A_WIDTH_DATA-1:0]    tl_o_a_data,
    output logic                          tl_o_a_corrupt,
    output logic                          tl_o_a_valid,
    input  logic                          tl_i_a_ready,

    input  logic [TL_D_WIDTH_OPCODE-1:0]  tl_i_d_opcode,
    input  logic [TL_D_WIDTH_PARAM-1:0]   tl_i_d_param,
    input  logic [TL_D_WIDTH_SIZE-1:0]    tl_i_d_size,
    input  logic [TL_D_WIDTH_SOURCE-1:0]  tl_i_d_source,
    input  logic [TL_D_WIDTH_SINK-1:0]    tl_i_d_sink,
    input  logic                          tl_i_d_denied,
    input  logic [TL_D_WIDTH_DATA-1:0]    tl_i_d_data,
    input  logic                          tl_i_d_corrupt,
    input  logic                          tl_i_d_valid,
    output logic                          tl_o_d_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_A_SEND = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [TL_A_WIDTH_OPCODE-1:0] C_A_GET          = TL_A_WIDTH_OPCODE'(4);
    localparam logic [TL_A_WIDTH_OPCODE-1:0] C_A_PUT_FULL     = TL_A_WIDTH_OPCODE'(0);
    localparam logic [TL_A_WIDTH_OPCODE-1:0] C_A_PUT_PARTIAL  = TL_A_WIDTH_OPCODE'(1);
    localparam logic [TL_D_WIDTH_OPCODE-1:0] C_D_ACK          = TL_D_WIDTH_OPCODE'(0);
    localparam logic [TL_D_WIDTH_OPCODE-1:0] C_D_ACK_DATA     = TL_D_WIDTH_OPCODE'(1);
    localparam logic [TL_A_WIDTH_SOURCE-1:0] C_A_SOURCE       = TL_A_WIDTH_SOURCE'(SOURCE_ID);
    localparam logic [TL_D_WIDTH_SOURCE-1:0] C_D_SOURCE       = TL_D_WIDTH_SOURCE'(SOURCE_ID);
    localparam logic [TL_A_WIDTH_SIZE-1:0]   C_A_SIZE_WORD    = TL_A_WIDTH_SIZE'(2);

    logic [1:0]                    state_q,  state_d;
    logic                          we_q,     we_d;
    logic [TL_A_WIDTH_ADDRESS-1:0] addr_q,   addr_d;
    logic [TL_A_WIDTH_MASK-1:0]    wmask_q,  wmask_d;
    logic [TL_A_WIDTH_DATA-1:0]    wdata_q,  wdata_d;
    logic [TL_D_WIDTH_DATA-1:0]    rdata_q,  rdata_d;
    logic                          err_q,    err_d;

    logic w_grant;
    logic w_aligned;
    logic w_d_accept;
    logic w_d_err;

    // Response fields that carry no meaning for single-beat word accesses.
    logic unused_d_fields;
    assign unused_d_fields = ^{tl_i_d_param, tl_i_d_size, tl_i_d_sink};

    assign w_grant    = (state_q == S_IDLE) && host_i_req;
    assign w_aligned  = (host_i_addr[1:0] == 2'b00);
    assign w_d_accept = (state_q == S_D_WAIT) && tl_i_d_valid;

    // The expected ack type depends on the direction of the latched request.
    always_comb begin
        w_d_err = tl_i_d_denied || tl_i_d_corrupt || (tl_i_d_source != C_D_SOURCE);
        if (we_q) begin
            w_d_err = w_d_err || (tl_i_d_opcode != C_D_ACK);
        end else begin
            w_d_err = w_d_err || (tl_i_d_opcode != C_D_ACK_DATA);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (host_i_req) begin
                    state_d = w_aligned ? S_A_SEND : S_RESP;
                end
            end
            S_A_SEND: begin
                if (tl_i_a_ready) begin
                    state_d = S_D_WAIT;
                end
            end
            S_D_WAIT: begin
                if (tl_i_d_valid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (w_grant) begin
            we_d    = host_i_we;
            addr_d  = host_i_addr;
            wmask_d = host_i_wmask;
            wdata_d = host_i_wdata;
        end
        // A misaligned request completes locally without touching the bus.
        if (w_grant && !w_aligned) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end else if (w_d_accept) begin
            err_d   = w_d_err;
            rdata_d = (!we_q && !w_d_err) ? tl_i_d_data : '0;
        end
    end

    always_comb begin
        host_o_gnt    = !rst && (state_q == S_IDLE) && host_i_req;
        tl_o_a_valid  = !rst && (state_q == S_A_SEND);
        tl_o_d_ready  = !rst && (state_q == S_D_WAIT);
        host_o_rvalid = !rst && (state_q == S_RESP);
    end

    always_comb begin
        tl_o_a_param   = '0;
        tl_o_a_size    = C_A_SIZE_WORD;
        tl_o_a_source  = C_A_SOURCE;
        tl_o_a_address = addr_q;
        tl_o_a_corrupt = 1'b0;
        if (we_q) begin
            tl_o_a_opcode = (wmask_q == {TL_A_WIDTH_MASK{1'b1}}) ? C_A_PUT_FULL : C_A_PUT_PARTIAL;
            tl_o_a_mask   = wmask_q;
            tl_o_a_data   = wdata_q;
        end else begin
            tl_o_a_opcode = C_A_GET;
            tl_o_a_mask   = '1;
            tl_o_a_data   = '0;
        end
    end

    assign host_o_rdata = rdata_q;
    assign host_o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg2tl_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg2tl_adapter
// Purpose  : Randomized self-checking bench for reg2tl_adapter against a
//            transaction-level expectation model.
// Revision : 1.0
// ============================================================================
module tb_reg2tl_adapter;

    localparam int SID = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_i_req, host_o_gnt, host_i_we;
    logic [31:0] host_i_addr, host_i_wdata;
    logic [3:0]  host_i_wmask;
    logic        host_o_rvalid, host_o_err;
    logic [31:0] host_o_rdata;
    logic [2:0]  tl_o_a_opcode, tl_o_a_param;
    logic [1:0]  tl_o_a_size;
    logic [7:0]  tl_o_a_source;
    logic [31:0] tl_o_a_address, tl_o_a_data;
    logic [3:0]  tl_o_a_mask;
    logic        tl_o_a_corrupt, tl_o_a_valid, tl_i_a_ready;
    logic [2:0]  tl_i_d_opcode, tl_i_d_param;
    logic [1:0]  tl_i_d_size;
    logic [7:0]  tl_i_d_source;
    logic [0:0]  tl_i_d_sink;
    logic        tl_i_d_denied, tl_i_d_corrupt, tl_i_d_valid, tl_o_d_ready;
    logic [31:0] tl_i_d_data;

    reg2tl_adapter #(.SOURCE_ID(SID)) dut (
        .clk(clk), .rst(rst),
        .host_i_req(host_i_req), .host_o_gnt(host_o_gnt), .host_i_we(host_i_we),
        .host_i_addr(host_i_addr), .host_i_wmask(host_i_wmask), .host_i_wdata(host_i_wdata),
        .host_o_rvalid(host_o_rvalid), .host_o_rdata(host_o_rdata), .host_o_err(host_o_err),
        .tl_o_a_opcode(tl_o_a_opcode), .tl_o_a_param(tl_o_a_param), .tl_o_a_size(tl_o_a_size),
        .tl_o_a_source(tl_o_a_source), .tl_o_a_address(tl_o_a_address), .tl_o_a_mask(tl_o_a_mask),
        .tl_o_a_data(tl_o_a_data), .tl_o_a_corrupt(tl_o_a_corrupt), .tl_o_a_valid(tl_o_a_valid),
        .tl_i_a_ready(tl_i_a_ready),
        .tl_i_d_opcode(tl_i_d_opcode), .tl_i_d_param(tl_i_d_param), .tl_i_d_size(tl_i_d_size),
        .tl_i_d_source(tl_i_d_source), .tl_i_d_sink(tl_i_d_sink), .tl_i_d_denied(tl_i_d_denied),
        .tl_i_d_data(tl_i_d_data), .tl_i_d_corrupt(tl_i_d_corrupt), .tl_i_d_valid(tl_i_d_valid),
        .tl_o_d_ready(tl_o_d_ready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic junk_host();
        host_i_req   = 1'b1;
        host_i_we    = 1'($urandom);
        host_i_addr  = $urandom;
        host_i_wmask = 4'($urandom);
        host_i_wdata = $urandom;
    endtask

    task automatic junk_d(input logic valid);
        tl_i_d_valid   = valid;
        tl_i_d_opcode  = 3'($urandom);
        tl_i_d_param   = 3'($urandom);
        tl_i_d_size    = 2'($urandom);
        tl_i_d_source  = 8'($urandom);
        tl_i_d_sink    = 1'($urandom);
        tl_i_d_denied  = 1'($urandom);
        tl_i_d_corrupt = 1'($urandom);
        tl_i_d_data    = $urandom;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        host_i_req   = 1'b0;
        tl_i_a_ready = 1'($urandom);
        junk_d(1'($urandom));
        #1;
        chk("gap_gnt", 64'(host_o_gnt), 64'd0);
        chk("gap_rvalid", 64'(host_o_rvalid), 64'd0);
        chk("gap_avalid", 64'(tl_o_a_valid), 64'd0);
        chk("gap_rdata_hold", 64'(host_o_rdata), 64'(last_rdata));
    endtask

    // One complete host transaction; expectations come straight from the
    // access rules, then the bus handshakes are played with the given delays.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] wmask,
                           input logic [31:0] wdata, input int a_dly, input int d_dly,
                           input logic [2:0] d_op, input logic [7:0] d_src, input logic d_den,
                           input logic d_cor, input logic [31:0] d_dat);
        logic        misal;
        logic [2:0]  e_op;
        logic [3:0]  e_mask;
        logic [31:0] e_data, e_rdata;
        logic        e_err;
        misal = (addr % 4) != 0;
        if (we) begin
            e_op   = (wmask == 4'hF) ? 3'd0 : 3'd1;
            e_mask = wmask;
            e_data = wdata;
        end else begin
            e_op   = 3'd4;
            e_mask = 4'hF;
            e_data = 32'd0;
        end
        if (misal) begin
            e_err   = 1'b1;
            e_rdata = 32'd0;
        end else begin
            e_err   = d_den || d_cor || (d_src != 8'(SID)) || (we ? (d_op != 3'd0) : (d_op != 3'd1));
            e_rdata = (!we && !e_err) ? d_dat : 32'd0;
        end

        @(negedge clk);
        host_i_req = 1'b1; host_i_we = we; host_i_addr = addr;
        host_i_wmask = wmask; host_i_wdata = wdata;
        tl_i_a_ready = 1'($urandom);
        junk_d(1'($urandom));
        #1;
        chk("gnt", 64'(host_o_gnt), 64'd1);
        chk("idle_avalid", 64'(tl_o_a_valid), 64'd0);
        chk("idle_dready", 64'(tl_o_d_ready), 64'd0);
        chk("idle_rvalid", 64'(host_o_rvalid), 64'd0);
        chk("hold_rdata", 64'(host_o_rdata), 64'(last_rdata));
        chk("hold_err", 64'(host_o_err), 64'(last_err));

        if (!misal) begin
            for (int i = 0; i <= a_dly; i++) begin
                @(negedge clk);
                junk_host();
                tl_i_a_ready = (i == a_dly);
                junk_d(1'($urandom));
                #1;
                chk("a_valid", 64'(tl_o_a_valid), 64'd1);
                chk("a_opcode", 64'(tl_o_a_opcode), 64'(e_op));
                chk("a_param", 64'(tl_o_a_param), 64'd0);
                chk("a_size", 64'(tl_o_a_size), 64'd2);
                chk("a_source", 64'(tl_o_a_source), 64'(SID));
                chk("a_address", 64'(tl_o_a_address), 64'(addr));
                chk("a_mask", 64'(tl_o_a_mask), 64'(e_mask));
                chk("a_data", 64'(tl_o_a_data), 64'(e_data));
                chk("a_corrupt", 64'(tl_o_a_corrupt), 64'd0);
                chk("busy_gnt_a", 64'(host_o_gnt), 64'd0);
                chk("a_dready", 64'(tl_o_d_ready), 64'd0);
                chk("a_rvalid", 64'(host_o_rvalid), 64'd0);
            end
            for (int j = 0; j <= d_dly; j++) begin
                @(negedge clk);
                junk_host();
                tl_i_a_ready = 1'($urandom);
                if (j == d_dly) begin
                    junk_d(1'b1);
                    tl_i_d_opcode = d_op; tl_i_d_source = d_src;
                    tl_i_d_denied = d_den; tl_i_d_corrupt = d_cor; tl_i_d_data = d_dat;
                end else begin
                    junk_d(1'b0);
                end
                #1;
                chk("d_ready", 64'(tl_o_d_ready), 64'd1);
                chk("d_avalid", 64'(tl_o_a_valid), 64'd0);
                chk("busy_gnt_d", 64'(host_o_gnt), 64'd0);
                chk("d_rvalid", 64'(host_o_rvalid), 64'd0);
            end
        end

        @(negedge clk);
        junk_host();
        tl_i_a_ready = 1'($urandom);
        junk_d(1'($urandom));
        #1;
        chk("rvalid", 64'(host_o_rvalid), 64'd1);
        chk("rdata", 64'(host_o_rdata), 64'(e_rdata));
        chk("err", 64'(host_o_err), 64'(e_err));
        chk("resp_gnt", 64'(host_o_gnt), 64'd0);
        chk("resp_avalid", 64'(tl_o_a_valid), 64'd0);
        chk("resp_dready", 64'(tl_o_d_ready), 64'd0);
        last_rdata = e_rdata;
        last_err   = e_err;
    endtask

    initial begin
        rst = 1'b1;
        junk_host();
        tl_i_a_ready = 1'b1;
        junk_d(1'b1);
        last_rdata = 32'd0;
        last_err   = 1'b0;
        @(negedge clk); #1;
        chk("rst_gnt", 64'(host_o_gnt), 64'd0);
        chk("rst_avalid", 64'(tl_o_a_valid), 64'd0);
        chk("rst_dready", 64'(tl_o_d_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        host_i_req = 1'b0;
        #1;
        chk("rst_rvalid", 64'(host_o_rvalid), 64'd0);
        chk("rst_rdata", 64'(host_o_rdata), 64'd0);
        chk("rst_err", 64'(host_o_err), 64'd0);

        // Directed cases
        run_txn(1'b0, 32'h100, 4'h0, 32'h0, 0, 0, 3'd1, 8'(SID), 1'b0, 1'b0, 32'hDEADBEEF);
        run_txn(1'b1, 32'h104, 4'hF, 32'h12345678, 0, 0, 3'd0, 8'(SID), 1'b0, 1'b0, 32'hAAAA5555);
        run_txn(1'b1, 32'h108, 4'h3, 32'h12345678, 0, 0, 3'd0, 8'(SID), 1'b0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h10C, 4'h0, 32'h0, 5, 3, 3'd1, 8'(SID), 1'b0, 1'b0, 32'hCAFEF00D);
        run_txn(1'b0, 32'h110, 4'h0, 32'h0, 0, 0, 3'd1, 8'(SID), 1'b1, 1'b0, 32'h11111111);
        run_txn(1'b0, 32'h114, 4'h0, 32'h0, 0, 0, 3'd0, 8'(SID), 1'b0, 1'b0, 32'h22222222);
        run_txn(1'b0, 32'h118, 4'h0, 32'h0, 0, 1, 3'd1, 8'(SID + 1), 1'b0, 1'b0, 32'h33333333);
        run_txn(1'b0, 32'h11C, 4'h0, 32'h0, 1, 0, 3'd1, 8'(SID), 1'b0, 1'b1, 32'h44444444);
        run_txn(1'b1, 32'h120, 4'hF, 32'h55555555, 0, 0, 3'd1, 8'(SID), 1'b0, 1'b0, 32'h66666666);
        run_txn(1'b0, 32'h102, 4'h0, 32'h0, 0, 0, 3'd1, 8'(SID), 1'b0, 1'b0, 32'h0);
        idle_cycle();

        // Reset while waiting on the D channel abandons the transaction.
        @(negedge clk);
        host_i_req = 1'b1; host_i_we = 1'b0; host_i_addr = 32'h200;
        tl_i_a_ready = 1'b0; junk_d(1'b0);
        #1; chk("rstd_gnt", 64'(host_o_gnt), 64'd1);
        @(negedge clk);
        junk_host(); tl_i_a_ready = 1'b1;
        #1; chk("rstd_avalid", 64'(tl_o_a_valid), 64'd1);
        @(negedge clk);
        junk_host(); junk_d(1'b0);
        #1; chk("rstd_dready", 64'(tl_o_d_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1; junk_host(); junk_d(1'b1);
        #1;
        chk("rstd_dready_in_rst", 64'(tl_o_d_ready), 64'd0);
        chk("rstd_gnt_in_rst", 64'(host_o_gnt), 64'd0);
        chk("rstd_avalid_in_rst", 64'(tl_o_a_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0; host_i_req = 1'b0; junk_d(1'b1);
        #1;
        chk("rstd_after_dready", 64'(tl_o_d_ready), 64'd0);
        chk("rstd_after_rvalid", 64'(host_o_rvalid), 64'd0);
        chk("rstd_after_rdata", 64'(host_o_rdata), 64'd0);
        chk("rstd_after_err", 64'(host_o_err), 64'd0);
        last_rdata = 32'd0;
        last_err   = 1'b0;
        repeat (3) idle_cycle();
        run_txn(1'b0, 32'h300, 4'h0, 32'h0, 0, 0, 3'd1, 8'(SID), 1'b0, 1'b0, 32'h0BADCAFE);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic [31:0] addr;
            logic [2:0]  d_op;
            logic [7:0]  d_src;
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
            we   = 1'($urandom);
            d_op = (we ? 3'd0 : 3'd1);
            if ($urandom_range(0, 7) == 0) d_op = 3'($urandom);
            d_src = 8'(SID);
            if ($urandom_range(0, 7) == 0) d_src = 8'($urandom);
            run_txn(we, addr, 4'($urandom), $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), d_op, d_src,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), $urandom);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
